alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 154 +++++++++++++++
 tb/tb_alu_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: ready/valid in, ready/valid out.
// The master drives operands and consumes results; the slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       aluop;
    logic             neg;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] O;
    logic [2:0]       flags;

    modport master (
        output in_valid, A, B, aluop, neg, out_ready,
        input  in_ready, out_valid, O, flags
    );

    modport slave (
        input  in_valid, A, B, aluop, neg, out_ready,
        output in_ready, out_valid, O, flags
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops, WIDTH-cycle shift-add multiply.
// One result register is held in DONE until consumed; consume and accept may share an edge.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int K  = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [1:0]         state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   o_q, o_d;
    logic [2:0]         flags_q, flags_d;

    logic               accept;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [K-1:0]       shamt;
    logic [WIDTH-1:0]   raw;
    logic [WIDTH-1:0]   fin;
    logic               carry;
    logic               ovf;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mul_fin;

    assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.O         = o_q;
    assign bus.flags     = flags_q;

    // Single-cycle datapath, evaluated straight from the live operands at acceptance.
    always_comb begin
        sum_ext  = {1'b0, bus.A} + {1'b0, bus.B};
        diff_ext = {1'b0, bus.A} - {1'b0, bus.B};
        shamt    = bus.B[K-1:0];
        raw      = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
        case (bus.aluop)
            OP_ADD: begin
                raw   = sum_ext[WIDTH-1:0];
                carry = sum_ext[WIDTH];
                ovf   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (raw[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                raw   = diff_ext[WIDTH-1:0];
                carry = diff_ext[WIDTH];
                ovf   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (raw[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND: raw = bus.A & bus.B;
            OP_OR:  raw = bus.A | bus.B;
            OP_XOR: raw = bus.A ^ bus.B;
            OP_SHL: raw = (32'(shamt) >= WIDTH) ? '0 : (bus.A << shamt);
            OP_SHR: raw = (32'(shamt) >= WIDTH) ? '0 : (bus.A >> shamt);
            default: raw = '0;
        endcase
        fin = bus.neg ? ~raw : raw;
    end

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
    always_comb begin
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mul_fin  = neg_q ? ~acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        o_d      = o_q;
        flags_d  = flags_q;
        if (accept) begin
            if (bus.aluop == OP_MUL) begin
                state_d  = S_MUL;
                mcand_d  = {{WIDTH{1'b0}}, bus.A};
                mplier_d = bus.B;
                acc_d    = '0;
                cnt_d    = '0;
                neg_d    = bus.neg;
            end else begin
                state_d  = S_DONE;
                o_d      = fin;
                flags_d  = {carry, ovf, (fin == '0)};
            end
        end else begin
            case (state_q)
                S_MUL: begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        o_d     = mul_fin;
                        flags_d = {(|acc_step[2*WIDTH-1:WIDTH]), 1'b0, (mul_fin == '0)};
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            o_q      <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            o_q      <= o_d;
            flags_q  <= flags_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq against an arithmetic reference model.
// Inputs change and outputs are sampled 1ns after each rising clock edge.
module tb_alu_seq;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   assertCount = 0;
    int   failCount   = 0;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result as {O, carry, overflow, zero}, computed with plain integer arithmetic.
    function automatic logic [WIDTH+2:0] refModel(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b, input logic ng);
        longint modv, ua, ub, sa, sb, full, sres, res;
        int     amt;
        logic   c, v, z;
        modv = longint'(1) << WIDTH;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = (ua >= modv / 2) ? ua - modv : ua;
        sb   = (ub >= modv / 2) ? ub - modv : ub;
        amt  = int'(ub % (longint'(1) << $clog2(WIDTH)));
        c    = 1'b0;
        v    = 1'b0;
        full = 0;
        case (op)
            3'd0: begin
                full = ua + ub;
                c    = (full >= modv);
                sres = sa + sb;
                v    = (sres >= modv / 2) || (sres < -(modv / 2));
            end
            3'd1: begin
                full = ua - ub;
                c    = (ua < ub);
                sres = sa - sb;
                v    = (sres >= modv / 2) || (sres < -(modv / 2));
            end
            3'd2: full = ua & ub;
            3'd3: full = ua | ub;
            3'd4: full = ua ^ ub;
            3'd5: full = (amt >= WIDTH) ? 0 : (ua << amt);
            3'd6: full = (amt >= WIDTH) ? 0 : (ua >> amt);
            default: begin
                full = ua * ub;
                c    = (full >= modv);
            end
        endcase
        res = ((full % modv) + modv) % modv;
        if (ng) res = modv - 1 - res;
        z = (res == 0);
        return {res[WIDTH-1:0], c, v, z};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag, input logic [WIDTH+2:0] exp);
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({tag, "_O"}, 32'(bus.O), 32'(exp[WIDTH+2:3]));
        checkOutput({tag, "_flags"}, 32'(bus.flags), 32'(exp[2:0]));
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic ng);
        bus.in_valid = v;
        bus.aluop    = op;
        bus.A        = a;
        bus.B        = b;
        bus.neg      = ng;
    endtask

    task automatic runSingle(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic ng, input logic [WIDTH+2:0] exp);
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, op, a, b, ng);
        step();
        bus.in_valid = 1'b0;
        checkResult(tag, exp);
        step();
        checkOutput({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [2:0]       opList [5];
        logic [7:0]       bList [5];
        logic [2:0]       op;
        logic [WIDTH-1:0] ra, rb;
        logic             rn;
        logic [WIDTH+2:0] expVec;
        int               lat;

        opList = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        bList  = '{8'h3C, 8'hC3, 8'h5A, 8'h09, 8'h08};

        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0);
        step();
        step();
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_O", 32'(bus.O), 32'd0);
        checkOutput("rst_flags", 32'(bus.flags), 32'd0);
        rst_n = 1'b1;
        step();

        runSingle("add_carry", 3'd0, 8'hF0, 8'h20, 1'b0, {8'h10, 3'b100});
        runSingle("sub_neg_ovf", 3'd1, 8'h80, 8'h01, 1'b1, {8'h80, 3'b010});
        runSingle("and_zero", 3'd2, 8'hAA, 8'h55, 1'b0, {8'h00, 3'b001});
        runSingle("and_neg", 3'd2, 8'hAA, 8'h55, 1'b1, {8'hFF, 3'b000});

        // MUL with a stalled consumer; operands are scribbled while the multiply runs.
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 3'd7, 8'h10, 8'h11, 1'b0);
        step();
        for (int i = 0; i < WIDTH; i++) begin
            checkOutput("mul_busy_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("mul_busy_valid", 32'(bus.out_valid), 32'd0);
            applyStimulus(1'b1, 3'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            step();
        end
        bus.in_valid = 1'b0;
        checkResult("mul", {8'h10, 3'b100});
        for (int i = 0; i < 5; i++) begin
            step();
            checkResult("mul_hold", {8'h10, 3'b100});
            checkOutput("mul_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        step();
        checkOutput("mul_consumed", 32'(bus.out_valid), 32'd0);

        // Back-to-back stream: directed logic/shift ops, then random non-MUL ops.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i < 5) begin
                op = opList[i];
                rb = bList[i];
                rn = 1'b0;
            end else begin
                op = 3'($urandom_range(0, 6));
                rb = WIDTH'($urandom);
                rn = 1'($urandom);
            end
            ra = WIDTH'($urandom);
            expVec = refModel(op, ra, rb, rn);
            applyStimulus(1'b1, op, ra, rb, rn);
            step();
            checkOutput("stream_in_ready", 32'(bus.in_ready), 32'd1);
            checkResult("stream", expVec);
        end
        bus.in_valid = 1'b0;
        step();
        checkOutput("stream_end", 32'(bus.out_valid), 32'd0);

        // Random ops of every kind, including MUL, with latency checks.
        for (int n = 0; n < 30; n++) begin
            op = 3'($urandom);
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rn = 1'($urandom);
            expVec = refModel(op, ra, rb, rn);
            applyStimulus(1'b1, op, ra, rb, rn);
            step();
            bus.in_valid = 1'b0;
            lat = 0;
            while (bus.out_valid !== 1'b1 && lat < 40) begin
                bus.A = WIDTH'($urandom);
                bus.B = WIDTH'($urandom);
                step();
                lat++;
            end
            checkOutput("rand_latency", 32'(lat), (op == 3'd7) ? 32'(WIDTH) : 32'd0);
            checkResult("rand", expVec);
            step();
            checkOutput("rand_drop", 32'(bus.out_valid), 32'd0);
        end

        // Reset pulse in the fourth cycle of a multiply discards it.
        applyStimulus(1'b1, 3'd7, 8'h37, 8'h5B, 1'b0);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #2;
        checkOutput("midmul_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midmul_rst_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checkOutput("midmul_no_valid", 32'(bus.out_valid), 32'd0);
        end
        checkOutput("midmul_ready", 32'(bus.in_ready), 32'd1);
        runSingle("post_rst_add", 3'd0, 8'h01, 8'h01, 1'b0, {8'h02, 3'b000});

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
